// File: rtl/snoop_fanout_ctrl.sv
// snoop_fanout_ctrl
//   Sequences one coherent snoop at a time across NoPorts snoop ports.
//   The AC request goes to every port except the initiator, and all CR
//   responses are collected. One OR-merged response is returned upstream.
//   One port's CD line is then forwarded and the others are drained.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   req_*                      upstream snoop request (valid/ready, addr, opcode, initiator)
//   ac_*                       per-port AC valid/ready, common registered addr/opcode
//   cr_*                       per-port CR valid/ready/resp (5 bits per port)
//   cd_*                       per-port CD valid/ready/data/last
//   rsp_*                      merged CR response upstream
//   dat_*                      forwarded CD line upstream
//   busy_o                     high while a transaction is in flight
module snoop_fanout_ctrl #(
  parameter int NoPorts   = 4,
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  localparam int IdxW     = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [AddrWidth-1:0]           req_addr_i,
  input  logic [3:0]                     req_snoop_i,
  input  logic [IdxW-1:0]                req_init_i,
  output logic [NoPorts-1:0]             ac_valid_o,
  input  logic [NoPorts-1:0]             ac_ready_i,
  output logic [AddrWidth-1:0]           ac_addr_o,
  output logic [3:0]                     ac_snoop_o,
  input  logic [NoPorts-1:0]             cr_valid_i,
  output logic [NoPorts-1:0]             cr_ready_o,
  input  logic [NoPorts*5-1:0]           cr_resp_i,
  input  logic [NoPorts-1:0]             cd_valid_i,
  output logic [NoPorts-1:0]             cd_ready_o,
  input  logic [NoPorts*DataWidth-1:0]   cd_data_i,
  input  logic [NoPorts-1:0]             cd_last_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [4:0]                     rsp_resp_o,
  output logic                           dat_valid_o,
  input  logic                           dat_ready_i,
  output logic [DataWidth-1:0]           dat_data_o,
  output logic                           dat_last_o,
  output logic                           busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_AC, S_RSP, S_DATA} state_e;

  state_e                 state_q;
  logic [NoPorts-1:0]     tgt_q, ac_sent_q, cr_got_q, dmask_q;
  logic [4:0]             resp_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [3:0]             snoop_q;
  logic [IdxW-1:0]        sel_q;

  logic [NoPorts-1:0]     tgt_req, ac_hs, cr_hs, cr_got_d, dt_hs, cd_done, dmask_d;
  logic [4:0]             resp_hs;
  logic [IdxW-1:0]        sel_d;
  logic [4:0]             cr_resp_arr [NoPorts];
  logic [DataWidth-1:0]   cd_data_arr [NoPorts];

  genvar gi;
  generate
    for (gi = 0; gi < NoPorts; gi++) begin : g_port
      // An initiator index >= NoPorts matches no port, so every port is snooped.
      assign tgt_req[gi]     = (req_init_i != IdxW'(gi));
      assign cr_resp_arr[gi] = cr_resp_i[gi*5 +: 5];
      assign cd_data_arr[gi] = cd_data_i[gi*DataWidth +: DataWidth];
      // Bit 0 of a CR response is DataTransfer: that port will send a CD line.
      assign dt_hs[gi]       = cr_hs[gi] & cr_resp_arr[gi][0];
      // The selected port follows the upstream ready; every other pending port is drained.
      assign cd_ready_o[gi]  = (state_q == S_DATA) && dmask_q[gi] &&
                               ((sel_q == IdxW'(gi)) ? dat_ready_i : 1'b1);
    end
  endgenerate

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign ac_addr_o   = addr_q;
  assign ac_snoop_o  = snoop_q;
  assign rsp_valid_o = (state_q == S_RSP);
  assign rsp_resp_o  = resp_q;
  assign ac_valid_o  = (state_q == S_AC) ? (tgt_q & ~ac_sent_q) : '0;
  // CR is accepted only after that port's AC went out, even while other ports' ACs are pending.
  assign cr_ready_o  = (state_q == S_AC) ? (tgt_q & ac_sent_q & ~cr_got_q) : '0;
  assign ac_hs       = ac_valid_o & ac_ready_i;
  assign cr_hs       = cr_valid_i & cr_ready_o;
  assign cr_got_d    = cr_got_q | cr_hs;
  assign cd_done     = cd_valid_i & cd_ready_o & cd_last_i;
  assign dmask_d     = dmask_q & ~cd_done;

  always_comb begin
    resp_hs     = '0;
    sel_d       = '0;
    dat_valid_o = 1'b0;
    dat_data_o  = '0;
    dat_last_o  = 1'b0;
    for (int i = 0; i < NoPorts; i++) begin
      if (cr_hs[i]) resp_hs = resp_hs | cr_resp_arr[i];
    end
    // The downward scan leaves the lowest set index in sel_d.
    for (int i = NoPorts - 1; i >= 0; i--) begin
      if (dmask_q[i]) sel_d = IdxW'(i);
    end
    for (int i = 0; i < NoPorts; i++) begin
      if (sel_q == IdxW'(i)) begin
        dat_valid_o = (state_q == S_DATA) && dmask_q[i] && cd_valid_i[i];
        dat_data_o  = cd_data_arr[i];
        dat_last_o  = cd_last_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      tgt_q     <= '0;
      ac_sent_q <= '0;
      cr_got_q  <= '0;
      dmask_q   <= '0;
      resp_q    <= '0;
      addr_q    <= '0;
      snoop_q   <= '0;
      sel_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_q    <= req_addr_i;
            snoop_q   <= req_snoop_i;
            tgt_q     <= tgt_req;
            ac_sent_q <= '0;
            cr_got_q  <= '0;
            dmask_q   <= '0;
            resp_q    <= '0;
            // With no target ports there is nothing to snoop, so go straight to the response.
            state_q   <= (tgt_req == '0) ? S_RSP : S_AC;
          end
        end
        S_AC: begin
          ac_sent_q <= ac_sent_q | ac_hs;
          cr_got_q  <= cr_got_d;
          resp_q    <= resp_q | resp_hs;
          dmask_q   <= dmask_q | dt_hs;
          if (cr_got_d == tgt_q) state_q <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready_i) begin
            if (dmask_q != '0) begin
              // The forwarded port is fixed here; it does not move on as ports finish.
              sel_q   <= sel_d;
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          dmask_q <= dmask_d;
          if (dmask_d == '0) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
